instruction_fetch_unit: RTL

Fetch stage sitting directly downstream of the PC stage. It samples the current program counter and issues a word read to instruction memory over a req/ack handshake. It holds the returned word in the IF/ID register under a valid/ready handshake toward decode. It pulses `pcAdvance` so the PC stage steps to the next or branch address, and it discards in-flight fetches on a taken branch (`flush`).

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch stage bundle: PC stage, instruction memory and decode handshakes
interface instruction_fetch_unit_if;
  logic [31:0] PC;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        decodeReady;
  logic [31:0] instruction;
  logic [31:0] instructionPC;
  logic        instructionValid;
  logic        pcAdvance;
  logic [1:0]  faultCode;

  modport master (
    input  PC, flush, imemAck, imemData, decodeReady,
    output imemReq, imemAddr, instruction, instructionPC, instructionValid, pcAdvance, faultCode
  );

  modport slave (
    output PC, flush, imemAck, imemData, decodeReady,
    input  imemReq, imemAddr, instruction, instructionPC, instructionValid, pcAdvance, faultCode
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC sample, imem req/ack read, IF/ID register toward decode
module instruction_fetch_unit #(
  parameter logic [31:0] NOP_WORD       = 32'hD503201F,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                        clock,
  input logic                        resetN,
  instruction_fetch_unit_if.master   fetch
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, addr_next;
  logic [31:0] instr_q, instr_next;
  logic [31:0] ipc_q, ipc_next;
  logic        valid_q, valid_next;
  logic        discard_q, discard_next;
  logic [7:0]  count_q, count_next;
  logic [1:0]  fault_q, fault_next;
  logic        req;
  logic        advance;
  logic        misaligned;

  assign misaligned = (fetch.PC[1:0] != 2'b00);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      addr_q    <= 32'h0;
      instr_q   <= NOP_WORD;
      ipc_q     <= 32'h0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      count_q   <= 8'h0;
      fault_q   <= FAULT_NONE;
    end else begin
      state     <= state_next;
      addr_q    <= addr_next;
      instr_q   <= instr_next;
      ipc_q     <= ipc_next;
      valid_q   <= valid_next;
      discard_q <= discard_next;
      count_q   <= count_next;
      fault_q   <= fault_next;
    end
  end

  always_comb begin
    state_next   = state;
    addr_next    = addr_q;
    instr_next   = instr_q;
    ipc_next     = ipc_q;
    valid_next   = valid_q;
    discard_next = discard_q;
    count_next   = count_q;
    fault_next   = fault_q;
    req          = 1'b0;
    advance      = 1'b0;

    unique case (state)
      IDLE: begin
        // A flush here means PC is being redirected this edge; sample it next cycle.
        if (fetch.flush) begin
          instr_next = NOP_WORD;
        end else begin
          addr_next = fetch.PC;
          if (misaligned) begin
            state_next = FAULT;
            fault_next = FAULT_MISALIGN;
          end else begin
            state_next   = FETCH;
            count_next   = 8'h0;
            discard_next = 1'b0;
          end
        end
      end

      FETCH: begin
        req = 1'b1;
        if (fetch.imemAck) begin
          if (fetch.flush || discard_q) begin
            discard_next = 1'b0;
            state_next   = IDLE;
            if (fetch.flush) instr_next = NOP_WORD;
          end else begin
            instr_next = fetch.imemData;
            ipc_next   = addr_q;
            valid_next = 1'b1;
            advance    = 1'b1;
            state_next = HOLD;
          end
        end else begin
          // The memory still owes us this word, so the request stays up until it lands.
          if (fetch.flush) begin
            discard_next = 1'b1;
            instr_next   = NOP_WORD;
          end
          if (count_q + 8'd1 == TIMEOUT_LIMIT) begin
            state_next   = FAULT;
            fault_next   = FAULT_TIMEOUT;
            discard_next = 1'b0;
          end else begin
            count_next = count_q + 8'd1;
          end
        end
      end

      HOLD: begin
        if (fetch.flush) begin
          valid_next = 1'b0;
          instr_next = NOP_WORD;
          state_next = IDLE;
        end else if (fetch.decodeReady) begin
          valid_next = 1'b0;
          addr_next  = fetch.PC;
          if (misaligned) begin
            state_next = FAULT;
            fault_next = FAULT_MISALIGN;
          end else begin
            state_next = FETCH;
            count_next = 8'h0;
          end
        end
      end

      FAULT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fetch.imemReq          = req;
  assign fetch.imemAddr         = addr_q;
  assign fetch.instruction      = instr_q;
  assign fetch.instructionPC    = ipc_q;
  assign fetch.instructionValid = valid_q;
  assign fetch.pcAdvance        = advance;
  assign fetch.faultCode        = fault_q;

endmodule
